// File: rtl/req_enc_pkg.sv
// Shared constants and types for the request encoder that feeds the
// register-file select path.
package req_enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Priority orders: high-first serves index 7 before index 0; low-first is the reverse.
    localparam bit PRI_HIGH_FIRST = 1'b0;
    localparam bit PRI_LOW_FIRST  = 1'b1;

    typedef logic [N_REQ-1:0] req_mask_t;
    typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/prio_sel8.sv
// Fixed-priority selector: picks one set bit of an 8-bit mask and returns
// its index. Purely combinational.
module prio_sel8
    import req_enc_pkg::*;
#(
    parameter bit LOW_FIRST = PRI_HIGH_FIRST
) (
    input  logic [N_REQ-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // The last matching bit in the scan wins, so the scan direction sets the priority.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (LOW_FIRST == PRI_LOW_FIRST) begin
                if (mask_i[N_REQ-1-i]) begin
                    idx_o = IDX_W'(N_REQ-1-i);
                end
            end else begin
                if (mask_i[i]) begin
                    idx_o = IDX_W'(i);
                end
            end
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/req_encoder_8to3.sv
// Sequential 8-to-3 encoder: gathers request strobes into a pending mask and
// hands out one index at a time over a valid/ready handshake.
module req_encoder_8to3
    import req_enc_pkg::*;
#(
    parameter bit LOW_FIRST = PRI_HIGH_FIRST
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [N_REQ-1:0] r_i,
    input  logic             rdy_i,
    output logic [IDX_W-1:0] y_o,
    output logic             v_o,
    output logic [N_REQ-1:0] pend_o,
    output logic             idle_o,
    output logic             ovf_o
);

    req_mask_t p_q, p_d;
    req_idx_t  y_q, y_d;
    logic      v_q, v_d;
    logic      ovf_q, ovf_d;

    req_mask_t rm;
    req_mask_t cand;
    req_idx_t  sel_idx;
    logic      sel_any;
    logic      ld;

    assign rm   = en_i ? r_i : '0;
    assign cand = p_q | rm;
    assign ld   = !v_q || rdy_i;

    prio_sel8 #(
        .LOW_FIRST (LOW_FIRST)
    ) u_sel (
        .mask_i (cand),
        .idx_o  (sel_idx),
        .any_o  (sel_any)
    );

    // A strobe on the index held in Y is not an overflow; only collisions with P count.
    always_comb begin
        y_d   = y_q;
        v_d   = v_q;
        p_d   = cand;
        ovf_d = ovf_q | (|(rm & p_q));
        if (ld) begin
            if (sel_any) begin
                y_d = sel_idx;
                v_d = 1'b1;
                p_d = cand & ~(req_mask_t'(1) << sel_idx);
            end else begin
                v_d = 1'b0;
                p_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q   <= '0;
            y_q   <= '0;
            v_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            p_q   <= p_d;
            y_q   <= y_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign y_o    = y_q;
    assign v_o    = v_q;
    assign pend_o = p_q;
    assign ovf_o  = ovf_q;
    assign idle_o = !v_q && (p_q == '0);

endmodule

// File: doc/req_encoder_8to3.md
Name: req_encoder_8to3

Overview:
- Sequential 8-to-3 encoder for the register-file select path; performs the inverse mapping of the 3-to-8 one-hot decoder.
- Collects request strobes on 8 one-hot/multi-hot lines into a pending mask.
- Emits one 3-bit index at a time over a valid/ready handshake, serializing simultaneous requests by fixed priority.
- Sits between request sources and the register-file decoder/write-select logic.

Parameters:
- LOW_FIRST, 0, priority order: 0 = index 7 highest priority, 1 = index 0 highest priority.

Ports:
- Clock  input  1  rising-edge clock; the single clock domain.
- Reset  input  1  synchronous, active-high reset.
- EN  input  1  request capture enable; when 0, R is ignored.
- R  input  8  request strobes, sampled every Clock edge; bit k requests index k.
- RDY  input  1  consumer accepts Y this cycle when V=1.
- Y  output  3  encoded index, registered.
- V  output  1  Y valid, registered.
- PEND  output  8  pending mask P; excludes the index currently held on Y.
- IDLE  output  1  combinational: V=0 and P=0.
- OVF  output  1  sticky: a request hit an already-pending bit.

Behaviour:
- Only state changes on rising Clock. Reset is sampled at the edge and dominates all other inputs.
- Reset values: P=8'h00, Y=3'b000, V=0, OVF=0. Reset mid-transfer discards the pending mask and any in-flight index without completing the handshake.
- Effective request: Rm = EN ? R : 8'h00.
- Candidate set: C = P | Rm.
- Load condition: LD = (V==0) or (V==1 and RDY==1).
- On LD with C≠0:
  - Y ← sel(C), V ← 1.
  - P ← C with bit sel(C) cleared.
- On LD with C=0: V ← 0, Y holds, P ← 8'h00.
- When not LD (V=1, RDY=0): Y and V hold, P ← C.
- sel(C): highest set index if LOW_FIRST=0, lowest set index if LOW_FIRST=1.
- Latency:
  - A request on R at edge n with the output idle gives V=1 and Y=index after edge n, i.e. visible in cycle n+1.
  - Back-to-back acceptance (RDY held 1) gives one index per cycle with no bubble.
- Handshake rules:
  - Y and V are stable while V=1 and RDY=0.
  - RDY while V=0 has no effect.
- Duplicate/merge rules:
  - Rm bit k with P[k]=1 already: merged into one pending request; OVF ← 1.
  - Rm bit k equal to the index currently on Y (in flight): not an overflow. Bit k becomes pending and is served again later.
  - Rm bit k in the same cycle that k is selected and loaded: k loads to Y, is not set in P, and does not set OVF. A single strobe yields exactly one service.
- EN=0: new requests are dropped; P and the output drain normally.
- All-zero input and empty P: no output activity; IDLE=1.
- OVF clears only on Reset.

Decomposition:
- Shared package req_enc_pkg holds:
  - constants N_REQ=8 and IDX_W=3;
  - priority-order encodings PRI_HIGH_FIRST=0 and PRI_LOW_FIRST=1.
- Sub-module prio_sel8: purely combinational. Takes an 8-bit mask and LOW_FIRST; produces the 3-bit index and an any-bit flag. Instantiated once; the top keeps all registers and handshake logic.

Test Plan:
- Reset, then a single request: assert Reset one cycle; check Y=000, V=0, P=00, OVF=0, IDLE=1. Then R=8'b0010_0000 for one cycle with EN=1, RDY=1 -> next cycle V=1, Y=101; following cycle V=0, IDLE=1.
- Multi-hot serialization: LOW_FIRST=0, R=8'b1000_0101 for one cycle, RDY=1 -> Y sequence 111, 010, 000 on three consecutive cycles with V=1, then V=0.
- Back-pressure: R=8'b0000_0011 with RDY=0 for 4 cycles -> Y=001 and V=1 held constant, PEND=8'b0000_0001. Raise RDY -> Y=000 next cycle, then V=0.
- Overflow and in-flight re-request: hold RDY=0 with Y=011 in flight; pulse R=8'b0000_1000 -> PEND[3]=1 and OVF stays 0. Pulse R=8'b0000_1000 again -> OVF=1. With RDY=1, index 3 is served once more.
- EN gating: EN=0 with R=8'hFF -> V stays 0, PEND=00. Then EN=1 with LOW_FIRST=1 and R=8'b1100_0000 -> Y=110 then Y=111.
- Reset mid-operation: R=8'hFF, RDY=1, assert Reset on cycle 3 -> the cycle after reset shows V=0, PEND=00, OVF=0, and no further output.
